cursor_select_ctrl: RTL and testbench
=====================================

CURSOR_SELECT_CTRL -- requirements
Module: cursor_select_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples a button needs before its debounced level changes.
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles select_loc is held after a destination commit.
REQ-003 clk  in  1  system clock; all logic is rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 btn_up, btn_down, btn_left, btn_right, btn_sel  in  1 each  raw pushbuttons, active-low, asynchronous to clk.
REQ-006 turn  in  1  player to move (1 = red, 0 = white), from game logic.
REQ-007 legal_move  in  28  four 7-bit entries {valid, x[2:0], y[2:0]} at [6:0], [13:7], [20:14], [27:21], registered one cycle after select_loc.
REQ-008 cursor_loc  out  6  free-moving highlight position {x, y}.
REQ-009 select_loc  out  6  committed location presented to game logic.
REQ-010 phase  out  1  0 = choosing piece, 1 = choosing destination.
REQ-011 move_ok  out  1  single-cycle pulse on an accepted destination commit.
REQ-012 sel_err  out  1  single-cycle pulse on a rejected piece or destination.

Function
REQ-013 Each button input SHALL pass a 2-FF synchronizer and an independent debounce counter; a differing sample resets the counter.
REQ-014 A press event SHALL be a single-cycle pulse on a debounced released-to-pressed transition; holding a button SHALL produce no repeats.
REQ-015 At most one event SHALL act per cycle, priority sel > up > down > left > right; lower-priority events in that cycle are discarded.
REQ-016 up: y+1; down: y-1; right: x+1; left: x-1; each SHALL saturate at 0 and 7 (no wrap).
REQ-017 FSM states: PICK, WAIT_LEGAL, DEST, SETTLE.
REQ-018 PICK: cursor moves; on sel, select_loc <= cursor_loc, 2-bit wait counter cleared, go to WAIT_LEGAL.
REQ-019 WAIT_LEGAL: ignore all events for exactly 2 cycles. Then, if all four valid bits are 0, pulse sel_err and return to PICK. Otherwise go to DEST.
REQ-020 DEST: cursor moves; select_loc SHALL remain at the committed piece.
REQ-021 DEST sel with cursor_loc == select_loc SHALL cancel and return to PICK with no pulse.
REQ-022 DEST sel with cursor_loc equal to the {x,y} of any valid entry captured on WAIT_LEGAL exit: select_loc <= cursor_loc, pulse move_ok, go to SETTLE.
REQ-023 DEST sel matching no valid entry and not cancelling: pulse sel_err, stay in DEST.
REQ-024 The four legal entries SHALL be latched on WAIT_LEGAL exit and used for all DEST comparisons.
REQ-025 SETTLE: ignore events for SETTLE_CYCLES cycles, then go to PICK; select_loc holds the destination so a continued jump is re-selected by game logic.
REQ-026 A change in turn in any state other than SETTLE SHALL force PICK on the next cycle, leaving select_loc unchanged.
REQ-027 phase SHALL be 1 in WAIT_LEGAL and DEST, and 0 in PICK and SETTLE.
REQ-028 move_ok and sel_err SHALL never assert in the same cycle.

Reset
REQ-029 On rst low, immediately: state PICK, cursor_loc = {3'd0,3'd1}, select_loc = {3'd0,3'd3} (empty square), phase 0, move_ok 0, sel_err 0, counters 0, debounced levels = released, latched entries 0.
REQ-030 Reset asserted mid-operation, including mid-debounce or in SETTLE, SHALL discard the in-flight event and all latched state.

Verification (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=8)
REQ-031 After reset, press btn_up held for 20 cycles -> cursor_loc 6'o01 to 6'o02 exactly once; a 3-cycle glitch press -> no change.
REQ-032 Cursor at x=7, press right 3 times -> cursor_loc x stays 7, no sel_err.
REQ-033 Cursor 6'o11, sel, legal_move = {7'b1_000_010, 21'b0} -> 2 cycles later phase=1; cursor to 6'o02, sel -> select_loc=6'o02, move_ok 1 cycle, PICK after 8 cycles.
REQ-034 Sel at a square with legal_move=0 -> sel_err pulse 3 cycles after the sel event, phase=0.
REQ-035 In DEST, sel on a non-listed square -> sel_err, stays DEST; then sel on the committed piece -> PICK, no pulse.
REQ-036 btn_sel and btn_up debounced in the same cycle -> only sel acts, cursor unchanged; toggle turn in DEST -> PICK next cycle.

Source files
------------

// File: rtl/cursor_select_if.sv
// Signal bundle between the cursor/select controller and the board side
// (raw pushbuttons, game logic). clk and rst stay plain ports on the controller.
interface cursor_select_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_sel;
    logic        turn;
    logic [27:0] legal_move;
    logic [5:0]  cursor_loc;
    logic [5:0]  select_loc;
    logic        phase;
    logic        move_ok;
    logic        sel_err;

    // No back-pressure: move_ok/sel_err are one-cycle pulses that game logic must
    // sample on the cycle they are high; legal_move answers select_loc one cycle later.
    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel, turn, legal_move,
        input  cursor_loc, select_loc, phase, move_ok, sel_err
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel, turn, legal_move,
        output cursor_loc, select_loc, phase, move_ok, sel_err
    );
endinterface

// File: rtl/cursor_select_ctrl.sv
// Board cursor and piece/destination selection: debounced buttons drive a cursor,
// and a small FSM commits a piece, checks legal destinations and commits the move.
module cursor_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic           clk,
    input  logic           rst,
    cursor_select_if.slave bus,
    output logic [1:0]     state_dbg
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [STW-1:0] ST_LAST = STW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PICK       = 2'd0,
        WAIT_LEGAL = 2'd1,
        DEST       = 2'd2,
        SETTLE     = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Bit order is the event priority order: sel, up, down, left, right.
    logic [4:0]     raw_n;
    logic [4:0]     sync1, sync2, level, press;
    logic [DBW-1:0] db_cnt [5];

    assign raw_n = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_sel};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= ~raw_n;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic ev_sel, ev_up, ev_down, ev_left, ev_right;
    assign ev_sel   = press[0];
    assign ev_up    = press[1] & ~press[0];
    assign ev_down  = press[2] & ~|press[1:0];
    assign ev_left  = press[3] & ~|press[2:0];
    assign ev_right = press[4] & ~|press[3:0];

    logic [5:0]     cursor_q, select_q, cursor_moved;
    logic [27:0]    legal_q;
    logic [1:0]     wait_cnt;
    logic [STW-1:0] settle_cnt;
    logic           turn_q, forced, wait_done, legal_any, dest_hit;
    logic           phase_o, move_ok_o, sel_err_o;

    always_comb begin
        cursor_moved = cursor_q;
        if (ev_up && cursor_q[2:0] != 3'd7)    cursor_moved[2:0] = cursor_q[2:0] + 3'd1;
        if (ev_down && cursor_q[2:0] != 3'd0)  cursor_moved[2:0] = cursor_q[2:0] - 3'd1;
        if (ev_left && cursor_q[5:3] != 3'd0)  cursor_moved[5:3] = cursor_q[5:3] - 3'd1;
        if (ev_right && cursor_q[5:3] != 3'd7) cursor_moved[5:3] = cursor_q[5:3] + 3'd1;
    end

    always_comb begin
        dest_hit = 1'b0;
        for (int i = 0; i < 4; i++)
            if (legal_q[7*i+6] && legal_q[7*i +: 6] == cursor_q) dest_hit = 1'b1;
    end

    assign forced    = (bus.turn != turn_q) && (state != SETTLE);
    assign wait_done = (wait_cnt == 2'd2);
    assign legal_any = bus.legal_move[6] | bus.legal_move[13] | bus.legal_move[20] | bus.legal_move[27];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= PICK;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (forced) begin
            state_nxt = PICK;
        end else begin
            case (state)
                PICK:       if (ev_sel) state_nxt = WAIT_LEGAL;
                WAIT_LEGAL: if (wait_done) state_nxt = legal_any ? DEST : PICK;
                DEST: begin
                    if (ev_sel) begin
                        if (cursor_q == select_q) state_nxt = PICK;
                        else if (dest_hit)        state_nxt = SETTLE;
                    end
                end
                SETTLE:     if (settle_cnt == ST_LAST) state_nxt = PICK;
                default:    state_nxt = PICK;
            endcase
        end
    end

    always_comb begin
        phase_o   = (state == WAIT_LEGAL) || (state == DEST);
        move_ok_o = 1'b0;
        sel_err_o = 1'b0;
        if (!forced) begin
            case (state)
                WAIT_LEGAL: sel_err_o = wait_done && !legal_any;
                DEST: begin
                    if (ev_sel && cursor_q != select_q) begin
                        move_ok_o = dest_hit;
                        sel_err_o = !dest_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursor_q   <= 6'o01;
            select_q   <= 6'o03;
            legal_q    <= '0;
            wait_cnt   <= '0;
            settle_cnt <= '0;
            turn_q     <= 1'b0;
        end else begin
            turn_q <= bus.turn;
            if (!forced) begin
                case (state)
                    PICK: begin
                        cursor_q <= cursor_moved;
                        if (ev_sel) begin
                            select_q <= cursor_q;
                            wait_cnt <= '0;
                        end
                    end
                    WAIT_LEGAL: begin
                        if (wait_done) legal_q  <= bus.legal_move;
                        else           wait_cnt <= wait_cnt + 2'd1;
                    end
                    DEST: begin
                        cursor_q <= cursor_moved;
                        if (move_ok_o) begin
                            select_q   <= cursor_q;
                            settle_cnt <= '0;
                        end
                    end
                    SETTLE: settle_cnt <= settle_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.cursor_loc = cursor_q;
    assign bus.select_loc = select_q;
    assign bus.phase      = phase_o;
    assign bus.move_ok    = move_ok_o;
    assign bus.sel_err    = sel_err_o;
    assign state_dbg      = state;
endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Bench for cursor_select_ctrl: scenario tasks with inline checks against a
// saturating-cursor / legal-destination-set model kept in the bench.
`timescale 1ns/1ps
module tb_cursor_select_ctrl;
    localparam int DB = 4;
    localparam int ST = 8;
    localparam logic [1:0] S_PICK = 2'd0, S_WAIT = 2'd1, S_DEST = 2'd2, S_SETTLE = 2'd3;
    localparam int B_SEL = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] state_dbg;

    cursor_select_if bus ();

    cursor_select_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int ok_pulses = 0, err_pulses = 0, both_pulses = 0;
    logic [5:0] exp_cur = 6'o01;
    logic [5:0] exp_sel = 6'o03;
    logic [5:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.move_ok === 1'b1) ok_pulses++;
        if (bus.sel_err === 1'b1) err_pulses++;
        if (bus.move_ok === 1'b1 && bus.sel_err === 1'b1) both_pulses++;
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_SEL:   bus.btn_sel = v;
            B_UP:    bus.btn_up = v;
            B_DOWN:  bus.btn_down = v;
            B_LEFT:  bus.btn_left = v;
            default: bus.btn_right = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b0);
        repeat (hold) @(negedge clk);
        set_btn(b, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    // Board geometry: x and y each clamp to 0..7.
    function automatic logic [5:0] model_move(input logic [5:0] c, input int b);
        int x, y;
        x = int'(c[5:3]);
        y = int'(c[2:0]);
        case (b)
            B_UP:    y = (y < 7) ? y + 1 : 7;
            B_DOWN:  y = (y > 0) ? y - 1 : 0;
            B_LEFT:  x = (x > 0) ? x - 1 : 0;
            B_RIGHT: x = (x < 7) ? x + 1 : 7;
            default: ;
        endcase
        return {3'(x), 3'(y)};
    endfunction

    function automatic logic in_legal(input logic [27:0] lm, input logic [5:0] sq);
        logic [6:0] e;
        for (int i = 0; i < 4; i++) begin
            e = lm[7*i +: 7];
            if (e[6] && e[5:0] == sq) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic goto(input logic [5:0] target);
        for (int n = 0; n < 16 && exp_cur != target; n++) begin
            int b;
            if (exp_cur[5:3] < target[5:3])      b = B_RIGHT;
            else if (exp_cur[5:3] > target[5:3]) b = B_LEFT;
            else if (exp_cur[2:0] < target[2:0]) b = B_UP;
            else                                 b = B_DOWN;
            press(b, 6);
            exp_cur = model_move(exp_cur, b);
        end
        checks++;
        if (bus.cursor_loc !== target) begin
            failures++;
            $display("FAIL goto: cursor_loc=%o expected=%o", bus.cursor_loc, target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cursor_loc !== 6'o01 || bus.select_loc !== 6'o03 || state_dbg !== S_PICK) begin
            failures++;
            $display("FAIL reset_locs: cursor=%o select=%o state=%0d expected 01 03 0",
                     bus.cursor_loc, bus.select_loc, state_dbg);
        end
        checks++;
        if (bus.phase !== 1'b0 || bus.move_ok !== 1'b0 || bus.sel_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: phase=%b move_ok=%b sel_err=%b expected 000",
                     bus.phase, bus.move_ok, bus.sel_err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_cur = 6'o01;
        exp_sel = 6'o03;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_debounce();
        press(B_UP, 20);
        exp_cur = model_move(exp_cur, B_UP);
        checks++;
        if (bus.cursor_loc !== 6'o02) begin
            failures++;
            $display("FAIL debounce_held: cursor_loc=%o expected=%o", bus.cursor_loc, 6'o02);
        end
        press(B_UP, 3);
        checks++;
        if (bus.cursor_loc !== 6'o02) begin
            failures++;
            $display("FAIL debounce_glitch: cursor_loc=%o expected=%o", bus.cursor_loc, 6'o02);
        end
    endtask

    task automatic test_saturate();
        int err0;
        goto(6'o72);
        err0 = err_pulses;
        for (int i = 0; i < 3; i++) begin
            press(B_RIGHT, 6);
            exp_cur = model_move(exp_cur, B_RIGHT);
        end
        checks++;
        if (bus.cursor_loc !== 6'o72 || err_pulses != err0) begin
            failures++;
            $display("FAIL sat_right: cursor_loc=%o errs=%0d expected=%o errs=%0d",
                     bus.cursor_loc, err_pulses - err0, 6'o72, 0);
        end
        for (int i = 0; i < 4; i++) begin
            press(B_DOWN, 6);
            exp_cur = model_move(exp_cur, B_DOWN);
        end
        checks++;
        if (bus.cursor_loc !== 6'o70) begin
            failures++;
            $display("FAIL sat_down: cursor_loc=%o expected=%o", bus.cursor_loc, 6'o70);
        end
    endtask

    task automatic test_random_moves();
        for (int i = 0; i < 16; i++) begin
            int b;
            b = $urandom_range(B_UP, B_RIGHT);
            exp_cur = model_move(exp_cur, b);
            exp_q.push_back(exp_cur);
            press(b, $urandom_range(6, 12));
            checks++;
            if (bus.cursor_loc !== exp_q[0]) begin
                failures++;
                $display("FAIL rand_move_%0d: cursor_loc=%o expected=%o", i, bus.cursor_loc, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_commit();
        int ok0;
        goto(6'o11);
        bus.legal_move = {7'b1_000_010, 21'b0};
        set_btn(B_SEL, 1'b0);
        repeat (7) @(negedge clk);
        set_btn(B_SEL, 1'b1);
        checks++;
        if (bus.phase !== 1'b1 || bus.select_loc !== 6'o11) begin
            failures++;
            $display("FAIL commit_piece: phase=%b select=%o expected 1 %o", bus.phase, bus.select_loc, 6'o11);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (state_dbg !== S_DEST || bus.phase !== 1'b1) begin
            failures++;
            $display("FAIL commit_dest: state=%0d phase=%b expected %0d 1", state_dbg, bus.phase, S_DEST);
        end
        repeat (8) @(negedge clk);
        goto(6'o02);
        ok0 = ok_pulses;
        set_btn(B_SEL, 1'b0);
        repeat (6) @(negedge clk);
        checks++;
        if (bus.move_ok !== 1'b1) begin
            failures++;
            $display("FAIL commit_move_ok: move_ok=%b expected 1", bus.move_ok);
        end
        @(negedge clk);
        set_btn(B_SEL, 1'b1);
        exp_sel = 6'o02;
        checks++;
        if (bus.move_ok !== 1'b0 || bus.select_loc !== exp_sel || state_dbg !== S_SETTLE) begin
            failures++;
            $display("FAIL commit_settle: move_ok=%b select=%o state=%0d expected 0 %o %0d",
                     bus.move_ok, bus.select_loc, state_dbg, exp_sel, S_SETTLE);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (state_dbg !== S_SETTLE) begin
            failures++;
            $display("FAIL settle_len: state=%0d expected %0d", state_dbg, S_SETTLE);
        end
        @(negedge clk);
        checks++;
        if (state_dbg !== S_PICK || bus.phase !== 1'b0 || ok_pulses != ok0 + 1) begin
            failures++;
            $display("FAIL settle_exit: state=%0d phase=%b ok=%0d expected 0 0 1",
                     state_dbg, bus.phase, ok_pulses - ok0);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_empty();
        bus.legal_move = '0;
        set_btn(B_SEL, 1'b0);
        repeat (8) @(negedge clk);
        set_btn(B_SEL, 1'b1);
        checks++;
        if (bus.sel_err !== 1'b0 || bus.phase !== 1'b1) begin
            failures++;
            $display("FAIL empty_wait: sel_err=%b phase=%b expected 0 1", bus.sel_err, bus.phase);
        end
        @(negedge clk);
        checks++;
        if (bus.sel_err !== 1'b1) begin
            failures++;
            $display("FAIL empty_err: sel_err=%b expected 1", bus.sel_err);
        end
        @(negedge clk);
        exp_sel = exp_cur;
        checks++;
        if (bus.sel_err !== 1'b0 || bus.phase !== 1'b0 || state_dbg !== S_PICK) begin
            failures++;
            $display("FAIL empty_back: sel_err=%b phase=%b state=%0d expected 0 0 0",
                     bus.sel_err, bus.phase, state_dbg);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_dest_reject();
        int ok0, err0;
        logic [5:0] piece;
        piece = exp_cur;
        bus.legal_move = {21'b0, 7'b1_101_101};
        press(B_SEL, 8);
        exp_sel = piece;
        goto((piece[2:0] == 3'd7) ? {piece[5:3], 3'd6} : {piece[5:3], piece[2:0] + 3'd1});
        err0 = err_pulses;
        ok0 = ok_pulses;
        press(B_SEL, 8);
        checks++;
        if (state_dbg !== S_DEST || err_pulses != err0 + 1 || ok_pulses != ok0) begin
            failures++;
            $display("FAIL reject: state=%0d errs=%0d oks=%0d expected %0d 1 0",
                     state_dbg, err_pulses - err0, ok_pulses - ok0, S_DEST);
        end
        goto(piece);
        press(B_SEL, 8);
        checks++;
        if (state_dbg !== S_PICK || err_pulses != err0 + 1 || ok_pulses != ok0 || bus.select_loc !== piece) begin
            failures++;
            $display("FAIL cancel: state=%0d errs=%0d oks=%0d select=%o expected 0 1 0 %o",
                     state_dbg, err_pulses - err0, ok_pulses - ok0, bus.select_loc, piece);
        end
    endtask

    task automatic test_simul_and_turn();
        logic [5:0] c;
        c = exp_cur;
        bus.legal_move = {14'b0, 7'b1_111_111, 7'b0};
        set_btn(B_SEL, 1'b0);
        set_btn(B_UP, 1'b0);
        repeat (8) @(negedge clk);
        set_btn(B_SEL, 1'b1);
        set_btn(B_UP, 1'b1);
        repeat (10) @(negedge clk);
        exp_sel = c;
        checks++;
        if (bus.cursor_loc !== c || state_dbg !== S_DEST || bus.select_loc !== c) begin
            failures++;
            $display("FAIL simul_sel_up: cursor=%o state=%0d select=%o expected %o %0d %o",
                     bus.cursor_loc, state_dbg, bus.select_loc, c, S_DEST, c);
        end
        bus.turn = ~bus.turn;
        @(negedge clk);
        checks++;
        if (state_dbg !== S_PICK || bus.select_loc !== exp_sel) begin
            failures++;
            $display("FAIL turn_force: state=%0d select=%o expected 0 %o", state_dbg, bus.select_loc, exp_sel);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random_dest();
        for (int it = 0; it < 5; it++) begin
            logic [27:0] lm;
            logic [6:0]  e;
            logic [5:0]  piece, target;
            int ok0, err0, k;
            for (int i = 0; i < 4; i++) lm[7*i +: 7] = 7'($urandom_range(0, 127));
            if (!(lm[6] | lm[13] | lm[20] | lm[27])) lm[6] = 1'b1;
            bus.legal_move = lm;
            piece = exp_cur;
            press(B_SEL, 8);
            exp_sel = piece;
            checks++;
            if (state_dbg !== S_DEST || bus.select_loc !== piece) begin
                failures++;
                $display("FAIL rdest_enter_%0d: state=%0d select=%o expected %0d %o",
                         it, state_dbg, bus.select_loc, S_DEST, piece);
            end
            target = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 3);
                for (int i = 0; i < 4; i++) begin
                    e = lm[7*((k + i) % 4) +: 7];
                    if (e[6]) target = e[5:0];
                end
            end
            goto(target);
            ok0 = ok_pulses;
            err0 = err_pulses;
            press(B_SEL, 8);
            if (target == piece) begin
                checks++;
                if (state_dbg !== S_PICK || ok_pulses != ok0 || err_pulses != err0) begin
                    failures++;
                    $display("FAIL rdest_cancel_%0d: state=%0d oks=%0d errs=%0d expected 0 0 0",
                             it, state_dbg, ok_pulses - ok0, err_pulses - err0);
                end
            end else if (in_legal(lm, target)) begin
                exp_sel = target;
                checks++;
                if (state_dbg !== S_PICK || ok_pulses != ok0 + 1 || err_pulses != err0 || bus.select_loc !== exp_sel) begin
                    failures++;
                    $display("FAIL rdest_move_%0d: state=%0d oks=%0d errs=%0d select=%o expected 0 1 0 %o",
                             it, state_dbg, ok_pulses - ok0, err_pulses - err0, bus.select_loc, exp_sel);
                end
            end else begin
                checks++;
                if (state_dbg !== S_DEST || ok_pulses != ok0 || err_pulses != err0 + 1) begin
                    failures++;
                    $display("FAIL rdest_reject_%0d: state=%0d oks=%0d errs=%0d expected %0d 0 1",
                             it, state_dbg, ok_pulses - ok0, err_pulses - err0, S_DEST);
                end
                bus.turn = ~bus.turn;
                repeat (2) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bus.turn = 1'b0;
        set_btn(B_UP, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        set_btn(B_UP, 1'b1);
        rst = 1'b1;
        exp_cur = 6'o01;
        exp_sel = 6'o03;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.cursor_loc !== 6'o01 || ok_pulses < 0) begin
            failures++;
            $display("FAIL reset_debounce: cursor_loc=%o expected=%o", bus.cursor_loc, 6'o01);
        end
        bus.legal_move = {21'b0, 7'b1_000_010};
        press(B_SEL, 8);
        goto(6'o02);
        set_btn(B_SEL, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if (state_dbg !== S_SETTLE) begin
            failures++;
            $display("FAIL reset_pre_settle: state=%0d expected %0d", state_dbg, S_SETTLE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (state_dbg !== S_PICK || bus.select_loc !== 6'o03 || bus.cursor_loc !== 6'o01) begin
            failures++;
            $display("FAIL reset_settle: state=%0d select=%o cursor=%o expected 0 03 01",
                     state_dbg, bus.select_loc, bus.cursor_loc);
        end
        set_btn(B_SEL, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_cur = 6'o01;
        repeat (12) @(negedge clk);
        checks++;
        if (state_dbg !== S_PICK || bus.cursor_loc !== 6'o01) begin
            failures++;
            $display("FAIL reset_recover: state=%0d cursor=%o expected 0 01", state_dbg, bus.cursor_loc);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_pulses != 0) begin
            failures++;
            $display("FAIL pulse_overlap: cycles=%0d expected 0", both_pulses);
        end
    endtask

    initial begin
        bus.btn_up = 1'b1;
        bus.btn_down = 1'b1;
        bus.btn_left = 1'b1;
        bus.btn_right = 1'b1;
        bus.btn_sel = 1'b1;
        bus.turn = 1'b0;
        bus.legal_move = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_debounce();
        test_saturate();
        test_random_moves();
        test_commit();
        test_empty();
        test_dest_reject();
        test_simul_and_turn();
        test_random_dest();
        test_reset_midflight();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
